// File: rtl/sisc_fetch.sv
// sisc_fetch -- instruction-fetch stage of the SISC computer.
//
// Owns the program counter, branch-target arithmetic, the instruction
// register and a one-entry prefetch buffer in front of a variable-latency
// instruction memory. The control FSM (ctrl) steers the stage with strobes
// and waits on fetch_rdy before loading the IR.
//
// Ports:
//   clk       system clock, all state on the rising edge
//   rst_f     asynchronous active-high reset
//   pc_rst    ctrl: PC <= RESET_PC, flush prefetch
//   pc_write  ctrl: update PC this edge
//   pc_sel    ctrl: 0 = PC+1, 1 = branch target
//   br_sel    ctrl: 1 = absolute (imm), 0 = relative (PC+imm)
//   ir_load   ctrl: move prefetch word into IR
//   im_ack    imem: im_rdata valid, request complete
//   im_rdata  imem: read data
//   im_req    imem: read request, held until im_ack
//   im_addr   imem: read address, stable while im_req high
//   ir        instruction register
//   opcode    ir[31:28]
//   mm        ir[27:24]
//   pc        current PC
//   fetch_rdy prefetch buffer holds the word at the current pc
//   fetch_err sticky: ir_load seen while fetch_rdy low
`timescale 1ns/1ps
module sisc_fetch #(
  parameter int              PC_W     = 16,
  parameter int              IR_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic            pc_rst,
  input  logic            pc_write,
  input  logic            pc_sel,
  input  logic            br_sel,
  input  logic            ir_load,
  input  logic            im_ack,
  input  logic [IR_W-1:0] im_rdata,
  output logic            im_req,
  output logic [PC_W-1:0] im_addr,
  output logic [IR_W-1:0] ir,
  output logic [3:0]      opcode,
  output logic [3:0]      mm,
  output logic [PC_W-1:0] pc,
  output logic            fetch_rdy,
  output logic            fetch_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t          state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [IR_W-1:0] ir_reg, ir_next;
  logic [IR_W-1:0] pf_data_reg, pf_data_next;
  logic [PC_W-1:0] pf_addr_reg, pf_addr_next;
  logic            pf_valid_reg, pf_valid_next;
  logic            im_req_reg, im_req_next;
  logic [PC_W-1:0] im_addr_reg, im_addr_next;
  logic            err_reg, err_next;

  logic            redirect;
  logic            rdy;
  logic            ack_take;
  logic            hit_next;
  logic [PC_W-1:0] imm;

  assign redirect = pc_rst | (pc_write & pc_sel);
  assign imm      = ir_reg[PC_W-1:0];
  assign rdy      = pf_valid_reg & (pf_addr_reg == pc_reg);
  // A response is only kept when nothing redirected the PC in the same cycle.
  assign ack_take = (state_reg == S_WAIT) & im_ack & ~redirect;

  // PC update; the relative base is the current (already incremented) pc.
  always_comb begin
    pc_next = pc_reg;
    if (pc_rst)
      pc_next = RESET_PC;
    else if (pc_write) begin
      if (!pc_sel)
        pc_next = pc_reg + PC_W'(1);
      else if (br_sel)
        pc_next = imm;
      else
        pc_next = pc_reg + imm;
    end
  end

  // Prefetch buffer
  always_comb begin
    pf_valid_next = pf_valid_reg;
    pf_data_next  = pf_data_reg;
    pf_addr_next  = pf_addr_reg;
    if (ack_take) begin
      pf_data_next = im_rdata;
      pf_addr_next = im_addr_reg;
    end
    if (redirect)
      pf_valid_next = 1'b0;
    else if (ack_take)
      pf_valid_next = 1'b1;
    else if (pf_valid_reg && (pf_addr_reg != pc_reg))
      pf_valid_next = 1'b0;
    else if (ir_load && rdy)
      pf_valid_next = 1'b0;
  end

  // Will the buffer hold the word for next cycle's pc?
  assign hit_next = pf_valid_next & (pf_addr_next == pc_next);

  // IR and sticky error
  always_comb begin
    ir_next  = ir_reg;
    err_next = err_reg;
    if (ir_load) begin
      if (rdy)
        ir_next = pf_data_reg;
      else
        err_next = 1'b1;
    end
  end

  // Request FSM. A request is never withdrawn: a redirect during WAIT parks
  // in DROP until the memory acks, and the stale response is thrown away.
  always_comb begin
    state_next   = state_reg;
    im_req_next  = im_req_reg;
    im_addr_next = im_addr_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (!hit_next && !redirect) begin
          im_req_next  = 1'b1;
          im_addr_next = pc_next;
          state_next   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (im_ack) begin
          im_req_next = 1'b0;
          state_next  = S_IDLE;
        end else if (redirect) begin
          state_next = S_DROP;
        end
      end
      S_DROP: begin
        if (im_ack) begin
          im_req_next = 1'b0;
          state_next  = S_IDLE;
        end
      end
      default: begin
        im_req_next = 1'b0;
        state_next  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      state_reg    <= S_IDLE;
      pc_reg       <= RESET_PC;
      ir_reg       <= '0;
      pf_data_reg  <= '0;
      pf_addr_reg  <= '0;
      pf_valid_reg <= 1'b0;
      im_req_reg   <= 1'b0;
      im_addr_reg  <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      ir_reg       <= ir_next;
      pf_data_reg  <= pf_data_next;
      pf_addr_reg  <= pf_addr_next;
      pf_valid_reg <= pf_valid_next;
      im_req_reg   <= im_req_next;
      im_addr_reg  <= im_addr_next;
      err_reg      <= err_next;
    end
  end

  assign im_req    = im_req_reg;
  assign im_addr   = im_addr_reg;
  assign ir        = ir_reg;
  assign opcode    = ir_reg[IR_W-1 -: 4];
  assign mm        = ir_reg[IR_W-5 -: 4];
  assign pc        = pc_reg;
  assign fetch_rdy = rdy;
  assign fetch_err = err_reg;

endmodule

// File: tb/tb_sisc_fetch.sv
// Testbench for sisc_fetch: a behavioural instruction memory with adjustable
// ack latency, directed ctrl strobes, and a request scoreboard whose monitor
// checks the address of every completed memory handshake in order.
`timescale 1ns/1ps
module tb_sisc_fetch;

  logic        clk = 1'b0;
  logic        rst_f;
  logic        pc_rst, pc_write, pc_sel, br_sel, ir_load;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic        im_req;
  logic [15:0] im_addr;
  logic [31:0] ir;
  logic [3:0]  opcode, mm;
  logic [15:0] pc;
  logic        fetch_rdy, fetch_err;

  int errors = 0;
  int checks = 0;
  int lat    = 1;
  int cnt    = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  sisc_fetch #(.PC_W(16), .IR_W(32), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_f(rst_f),
    .pc_rst(pc_rst), .pc_write(pc_write), .pc_sel(pc_sel), .br_sel(br_sel),
    .ir_load(ir_load), .im_ack(im_ack), .im_rdata(im_rdata),
    .im_req(im_req), .im_addr(im_addr), .ir(ir), .opcode(opcode), .mm(mm),
    .pc(pc), .fetch_rdy(fetch_rdy), .fetch_err(fetch_err)
  );

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 32'h1810_0005;
      16'h0001: return 32'h3000_0010;
      16'h0010: return 32'h4000_0030;
      16'h0030: return 32'h5000_000F;
      16'h000F: return 32'h7000_FFFE;
      16'h000E: return 32'h8000_0040;
      16'h0040: return 32'h9000_FFFF;
      16'hFFFF: return 32'hA000_0000;
      default:  return {16'hEE00, a};
    endcase
  endfunction

  // Instruction memory: acks `lat` cycles after seeing a request.
  always @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      im_ack   <= 1'b0;
      im_rdata <= '0;
      cnt      <= 0;
    end else begin
      im_ack <= 1'b0;
      if (im_req && !im_ack) begin
        if (cnt >= lat - 1) begin
          im_ack   <= 1'b1;
          im_rdata <= mem_word(im_addr);
          cnt      <= 0;
        end else begin
          cnt <= cnt + 1;
        end
      end
    end
  end

  // Monitor: every completed handshake must match the next expected address.
  always @(negedge clk) begin
    if (!rst_f && im_req && im_ack) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL req_addr: got %h, expected no request", im_addr);
      end else begin
        if (im_addr !== exp_q[0]) begin
          errors++;
          $display("FAIL req_addr: got %h, expected %h", im_addr, exp_q[0]);
        end else
          $display("req handshake addr=%h ok", im_addr);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the first negedge with fetch_rdy high.
  task automatic wait_rdy(input string name);
    int n = 0;
    while (!fetch_rdy && n < 64) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!fetch_rdy) begin
      errors++;
      $display("FAIL %s: fetch_rdy timeout got 0, expected 1", name);
    end
  endtask

  // Called at a negedge: hold strobes for one rising edge, then clear them.
  task automatic pulse(input logic il, input logic pw, input logic ps, input logic bs);
    ir_load = il; pc_write = pw; pc_sel = ps; br_sel = bs;
    @(negedge clk);
    ir_load = 1'b0; pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
  endtask

  initial begin
    rst_f = 1'b1;
    pc_rst = 1'b0; pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0; ir_load = 1'b0;
    exp_q.push_back(16'h0000);
    repeat (2) @(negedge clk);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_im_req", 32'(im_req), 32'h0);
    chk("rst_im_addr", 32'(im_addr), 32'h0);
    chk("rst_fetch_rdy", 32'(fetch_rdy), 32'h0);
    chk("rst_fetch_err", 32'(fetch_err), 32'h0);

    // 1: first fetch after reset release
    rst_f = 1'b0;
    @(negedge clk);
    chk("first_req", 32'(im_req), 32'h1);
    chk("first_addr", 32'(im_addr), 32'h0);
    wait_rdy("first_rdy");
    exp_q.push_back(16'h0001);
    pulse(1, 1, 0, 0);
    chk("t1_ir", ir, 32'h1810_0005);
    chk("t1_opcode", 32'(opcode), 32'h1);
    chk("t1_mm", 32'(mm), 32'h8);
    chk("t1_pc", 32'(pc), 32'h1);

    // 2: absolute and relative branches
    wait_rdy("w1");
    exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0010);
    pulse(1, 1, 0, 0);
    chk("ir_3000", ir, 32'h3000_0010);
    chk("pc_2", 32'(pc), 32'h2);
    pulse(0, 1, 1, 1);
    chk("abs_pc_10", 32'(pc), 32'h10);
    wait_rdy("w10");
    exp_q.push_back(16'h0010);
    exp_q.push_back(16'h0030);
    pulse(1, 0, 0, 0);
    chk("ir_4000", ir, 32'h4000_0030);
    chk("pc_hold_10", 32'(pc), 32'h10);
    pulse(0, 1, 1, 1);
    chk("abs_pc_30", 32'(pc), 32'h30);
    wait_rdy("w30");
    exp_q.push_back(16'h0030);
    exp_q.push_back(16'h000F);
    pulse(1, 0, 0, 0);
    pulse(0, 1, 1, 1);
    chk("abs_pc_0f", 32'(pc), 32'h0F);
    wait_rdy("w0f");
    exp_q.push_back(16'h0010);
    exp_q.push_back(16'h000E);
    pulse(1, 1, 0, 0);
    chk("ir_7000", ir, 32'h7000_FFFE);
    chk("pc_10b", 32'(pc), 32'h10);
    pulse(0, 1, 1, 0);
    chk("rel_pc_0e", 32'(pc), 32'h0E);

    // 3: redirect while a slow request is outstanding
    wait_rdy("w0e");
    lat = 4;
    exp_q.push_back(16'h000F);
    exp_q.push_back(16'h0040);
    pulse(1, 1, 0, 0);
    chk("pc_0f_seq", 32'(pc), 32'h0F);
    pulse(0, 1, 1, 1);
    chk("abs_pc_40", 32'(pc), 32'h40);
    for (int i = 0; i < 4; i++) begin
      chk("drop_req_held", 32'(im_req), 32'h1);
      chk("drop_addr_held", 32'(im_addr), 32'h0F);
      chk("drop_rdy_low", 32'(fetch_rdy), 32'h0);
      @(negedge clk);
    end
    chk("drop_req_gap", 32'(im_req), 32'h0);
    chk("drop_discard", 32'(fetch_rdy), 32'h0);

    // 4: PC wrap
    lat = 1;
    wait_rdy("w40");
    exp_q.push_back(16'h0040);
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000);
    pulse(1, 0, 0, 0);
    pulse(0, 1, 1, 1);
    chk("abs_pc_ffff", 32'(pc), 32'hFFFF);
    wait_rdy("wffff");
    pulse(1, 1, 0, 0);
    chk("wrap_pc", 32'(pc), 32'h0);
    chk("wrap_req", 32'(im_req), 32'h1);
    chk("wrap_addr", 32'(im_addr), 32'h0);

    // 5: ir_load before the memory has answered
    pulse(1, 0, 0, 0);
    chk("err_ir_hold", ir, 32'hA000_0000);
    chk("err_set", 32'(fetch_err), 32'h1);
    lat = 4;
    wait_rdy("w0b");
    pulse(1, 1, 0, 0);
    chk("err_ir_next", ir, 32'h1810_0005);
    chk("err_sticky", 32'(fetch_err), 32'h1);
    chk("err_pc_1", 32'(pc), 32'h1);

    // 6: async reset in the middle of a request
    @(negedge clk);
    chk("pre_rst_req", 32'(im_req), 32'h1);
    rst_f = 1'b1;
    #1;
    chk("arst_im_req", 32'(im_req), 32'h0);
    chk("arst_im_addr", 32'(im_addr), 32'h0);
    chk("arst_pc", 32'(pc), 32'h0);
    chk("arst_ir", ir, 32'h0);
    chk("arst_opcode", 32'(opcode), 32'h0);
    chk("arst_fetch_rdy", 32'(fetch_rdy), 32'h0);
    chk("arst_fetch_err", 32'(fetch_err), 32'h0);
    @(negedge clk);
    lat = 1;
    exp_q.push_back(16'h0000);
    rst_f = 1'b0;
    @(negedge clk);
    chk("post_rst_pc", 32'(pc), 32'h0);
    wait_rdy("w_post");
    chk("post_rst_err", 32'(fetch_err), 32'h0);
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
